// File: rtl/goe_arb_pkg.sv
// Shared constants for the goe_arb packet arbiter: word layout, tags and FSM encodings.
package goe_arb_pkg;

  localparam int unsigned WORD_W    = 134;
  localparam int unsigned TAG_MSB   = 133;
  localparam int unsigned TAG_LSB   = 132;
  localparam int unsigned OPORT_MSB = 117;
  localparam int unsigned OPORT_LSB = 112;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_MID  = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  function automatic logic is_tail(input logic [WORD_W-1:0] w);
    return w[TAG_MSB:TAG_LSB] == TAG_TAIL;
  endfunction

endpackage

// File: rtl/goe_arb_if.sv
// Bus bundle between the two packet sources, the goe_arb block and the goe output stage.
interface goe_arb_if;
  import goe_arb_pkg::*;

  logic              in_data_wr_0;
  logic              in_data_wr_1;
  logic [WORD_W-1:0] in_data_0;
  logic [WORD_W-1:0] in_data_1;
  logic              in_valid_wr_0;
  logic              in_valid_wr_1;
  logic              in_valid_0;
  logic              in_valid_1;
  logic              in_alf_0;
  logic              in_alf_1;
  logic              out_goe_data_wr;
  logic [WORD_W-1:0] out_goe_data;
  logic              out_goe_valid_wr;
  logic              out_goe_valid;
  logic [15:0]       pkt_cnt_0;
  logic [15:0]       pkt_cnt_1;
  logic [15:0]       ovf_cnt;

  modport master (
    output in_data_wr_0, in_data_wr_1, in_data_0, in_data_1,
    output in_valid_wr_0, in_valid_wr_1, in_valid_0, in_valid_1,
    input  in_alf_0, in_alf_1,
    input  out_goe_data_wr, out_goe_data, out_goe_valid_wr, out_goe_valid,
    input  pkt_cnt_0, pkt_cnt_1, ovf_cnt
  );

  modport slave (
    input  in_data_wr_0, in_data_wr_1, in_data_0, in_data_1,
    input  in_valid_wr_0, in_valid_wr_1, in_valid_0, in_valid_1,
    output in_alf_0, in_alf_1,
    output out_goe_data_wr, out_goe_data, out_goe_valid_wr, out_goe_valid,
    output pkt_cnt_0, pkt_cnt_1, ovf_cnt
  );

endinterface

// File: rtl/goe_arb_fifo.sv
// Synchronous FIFO with registered read data and occupancy count; writes to a full FIFO are dropped.
module goe_arb_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Aw    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [Aw:0]      used
);

  localparam int unsigned Depth = 1 << Aw;

  logic [Width-1:0] mem [Depth];
  logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [Aw:0]      used_q;
  logic [Width-1:0] rd_data_q;
  logic             wr_ok, rd_ok;

  assign full    = used_q == (Aw+1)'(Depth);
  assign empty   = used_q == '0;
  assign used    = used_q;
  assign rd_data = rd_data_q;
  // Oldest entry, visible before it is read so the consumer can look ahead at it.
  assign head    = mem[rd_ptr_q];
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      used_q    <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + Aw'(1);
      if (rd_ok) begin
        rd_ptr_q  <= rd_ptr_q + Aw'(1);
        rd_data_q <= mem[rd_ptr_q];
      end
      used_q <= used_q + (Aw+1)'(wr_ok) - (Aw+1)'(rd_ok);
    end
  end

endmodule

// File: rtl/goe_arb.sv
// Packet-granular round-robin merge of two store-and-forward sources onto the goe input.
module goe_arb
  import goe_arb_pkg::*;
#(
  parameter int unsigned DATA_AW       = 8,
  parameter int unsigned PKT_AW        = 4,
  parameter int unsigned MAX_PKT_WORDS = 128
) (
  input logic      clk,
  input logic      rst,
  goe_arb_if.slave bus
);

  localparam int unsigned AlfData = (1 << DATA_AW) - MAX_PKT_WORDS;
  localparam int unsigned AlfDesc = (1 << PKT_AW) - 1;

  logic [1:0]         d_wr, d_rd, d_full, d_empty;
  logic [WORD_W-1:0]  d_wdata [2];
  logic [WORD_W-1:0]  d_rdata [2];
  logic [WORD_W-1:0]  d_head  [2];
  logic [DATA_AW:0]   d_used  [2];
  logic [1:0]         p_wr, p_rd, p_full, p_empty;
  logic [0:0]         p_wdata [2];
  logic [0:0]         p_rdata [2];
  logic [0:0]         unused_desc_head [2];
  logic [PKT_AW:0]    p_used  [2];

  assign d_wr       = {bus.in_data_wr_1, bus.in_data_wr_0};
  assign d_wdata[0] = bus.in_data_0;
  assign d_wdata[1] = bus.in_data_1;
  assign p_wr       = {bus.in_valid_wr_1, bus.in_valid_wr_0};
  assign p_wdata[0] = bus.in_valid_0;
  assign p_wdata[1] = bus.in_valid_1;

  for (genvar g = 0; g < 2; g++) begin : g_src
    goe_arb_fifo #(.Width(WORD_W), .Aw(DATA_AW)) u_data (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (d_wr[g]),
      .wr_data (d_wdata[g]),
      .rd_en   (d_rd[g]),
      .rd_data (d_rdata[g]),
      .head    (d_head[g]),
      .full    (d_full[g]),
      .empty   (d_empty[g]),
      .used    (d_used[g])
    );

    goe_arb_fifo #(.Width(1), .Aw(PKT_AW)) u_desc (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (p_wr[g]),
      .wr_data (p_wdata[g]),
      .rd_en   (p_rd[g]),
      .rd_data (p_rdata[g]),
      .head    (unused_desc_head[g]),
      .full    (p_full[g]),
      .empty   (p_empty[g]),
      .used    (p_used[g])
    );
  end

  assign bus.in_alf_0 = (d_used[0] > (DATA_AW+1)'(AlfData)) ||
                        (p_used[0] >= (PKT_AW+1)'(AlfDesc));
  assign bus.in_alf_1 = (d_used[1] > (DATA_AW+1)'(AlfData)) ||
                        (p_used[1] >= (PKT_AW+1)'(AlfDesc));

  logic [0:0] state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       rd_go, head_tail;
  logic       vld_q, src_q, tail_q;
  logic [15:0] pkt_cnt0_q, pkt_cnt1_q, ovf_q, ovf_d;
  logic [2:0]  drops;
  logic [16:0] ovf_sum;

  // gnt_q keeps the last granted source between packets, so it doubles as the round-robin pointer.
  assign head_tail = gnt_q ? is_tail(d_head[1]) : is_tail(d_head[0]);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    p_rd    = 2'b00;
    rd_go   = 1'b0;
    case (state_q)
      IDLE: begin
        if (p_empty != 2'b11) begin
          gnt_d   = (p_empty == 2'b00) ? ~gnt_q : p_empty[0];
          p_rd    = gnt_d ? 2'b10 : 2'b01;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!d_empty[gnt_q]) begin
          rd_go = 1'b1;
          if (head_tail) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign d_rd = rd_go ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    drops   = 3'(d_wr[0] & d_full[0]) + 3'(d_wr[1] & d_full[1]) +
              3'(p_wr[0] & p_full[0]) + 3'(p_wr[1] & p_full[1]);
    ovf_sum = {1'b0, ovf_q} + 17'(drops);
    ovf_d   = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b1;
      vld_q      <= 1'b0;
      src_q      <= 1'b0;
      tail_q     <= 1'b0;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
      ovf_q      <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vld_q   <= rd_go;
      tail_q  <= rd_go && head_tail;
      if (rd_go) src_q <= gnt_q;
      if (vld_q && tail_q) begin
        if (src_q) pkt_cnt1_q <= pkt_cnt1_q + 16'd1;
        else       pkt_cnt0_q <= pkt_cnt0_q + 16'd1;
      end
      ovf_q <= ovf_d;
    end
  end

  // Descriptor read data is held until the next grant, which never precedes the tail word.
  assign bus.out_goe_data_wr  = vld_q;
  assign bus.out_goe_data     = vld_q ? (src_q ? d_rdata[1] : d_rdata[0]) : '0;
  assign bus.out_goe_valid_wr = vld_q && tail_q;
  assign bus.out_goe_valid    = vld_q && tail_q && (src_q ? p_rdata[1][0] : p_rdata[0][0]);
  assign bus.pkt_cnt_0        = pkt_cnt0_q;
  assign bus.pkt_cnt_1        = pkt_cnt1_q;
  assign bus.ovf_cnt          = ovf_q;

endmodule

// File: doc/goe_arb.md
# goe_arb

Packet-granular round-robin arbiter that merges two 134-bit packet sources onto the single input of the goe output stage. Each source is buffered store-and-forward in its own FIFO. Only complete packets are granted, so goe never sees interleaved words. Sits directly upstream of goe, between the UDA pipeline (source 0) and the CPU/control injection path (source 1).

## Interface
Parameters:
- DATA_AW, 8: data FIFO address width (256 words per source).
- PKT_AW, 4: packet-descriptor FIFO address width (16 packets per source).
- MAX_PKT_WORDS, 128: largest legal packet in words; sets the almost-full threshold.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- in_data_wr_0 / in_data_wr_1  in  1  word strobe, source 0 / 1.
- in_data_0 / in_data_1  in  134  word; [133:132] = 01 head, 11 middle, 10 tail; [117:112] = output port.
- in_valid_wr_0 / in_valid_wr_1  in  1  packet-end strobe, asserted with or after the tail word.
- in_valid_0 / in_valid_1  in  1  packet keep (1) / discard (0) flag.
- in_alf_0 / in_alf_1  out  1  almost full; the source must not start a new packet while this is high.
- out_goe_data_wr  out  1  word strobe to goe.
- out_goe_data  out  134  word to goe.
- out_goe_valid_wr  out  1  packet-end strobe to goe; coincides with the tail word.
- out_goe_valid  out  1  keep/discard flag to goe.
- pkt_cnt_0 / pkt_cnt_1  out  16  packets forwarded per source; wraps.
- ovf_cnt  out  16  words dropped on full FIFO, both sources combined; saturates at 0xFFFF.

## Operation
- Per source:
  - Data FIFO stores every in_data_wr word.
  - Descriptor FIFO stores in_valid on each in_valid_wr.
  - A packet is eligible once its descriptor is present.
- in_alf_n = data used > 2^DATA_AW − MAX_PKT_WORDS, or descriptor used ≥ 2^PKT_AW − 1.
- Overflow:
  - A word written to a full data FIFO is dropped and ovf_cnt increments.
  - A valid_wr written to a full descriptor FIFO is dropped and ovf_cnt increments.
  - No other recovery; the bench must treat this as a protocol violation.
- FSM states:
  - IDLE:
    - If either descriptor FIFO is non-empty, grant a source.
    - If both are non-empty, grant the source ≠ last_grant.
    - Pop the granted descriptor, go to SEND.
    - last_grant resets to 1, so source 0 wins the first tie.
  - SEND:
    - Read one word per cycle from the granted data FIFO.
    - When the word read carries tag 10, go to IDLE and update last_grant.
  - Both states, plus the grant register, reset to IDLE.
- Output:
  - Words are registered before output.
  - out_goe_valid_wr = 1 and out_goe_valid = the popped descriptor, both on the tail word only.
  - All outputs are 0 on non-strobe cycles.
- pkt_cnt_n increments on the tail word of a source-n packet, regardless of the valid flag.
- Simultaneous writes on both sources are independent; both are always accepted.
- Reset mid-packet:
  - Flushes both FIFOs and all counters, forces IDLE, and drives outputs low.
  - A partially transmitted packet is truncated; goe recovers on its next head word.

## Timing
- Reset value of every output is 0.
- Eligibility → first output word:
  - Cycle N: in_valid_wr write.
  - Cycle N+1: descriptor visible; IDLE grants.
  - Cycle N+2: first data read issued.
  - Cycle N+3: head word on out_goe_data.
- Packet of W words occupies W consecutive output cycles.
- Exactly one idle cycle between consecutive packets (the IDLE state).
- Throughput is one word per cycle within a packet, with no gaps.
- in_alf_n updates one cycle after the write/read that changes occupancy.

## Structure
- Shared package entries:
  - Tag constants TAG_HEAD = 2'b01, TAG_MID = 2'b11, TAG_TAIL = 2'b10.
  - Field positions TAG_MSB/LSB = 133/132, OPORT_MSB/LSB = 117/112.
  - State encodings IDLE / SEND.
- Sub-module: goe_arb_fifo, a parameterised width/depth synchronous FIFO with used count and first-word-fall-through disabled.
  - Instantiated four times: two data, two descriptor.

## Test plan
- Single source-0 packet, 4 words, valid=1 → head appears 3 cycles after valid_wr; 4 contiguous words; valid_wr+valid=1 on word 4; pkt_cnt_0=1.
- Both sources hold a 3-word packet at the same cycle after reset → source 0 sent first, one idle cycle, then source 1; pkt_cnt_0 = pkt_cnt_1 = 1.
- Source 1 streams back-to-back 2-word packets while source 0 holds one → grants strictly alternate; source 0 is never starved more than one packet.
- Source 0 writes 130 words without valid_wr → in_alf_0 = 1 once used > 128. Continuing to 257 words → ovf_cnt = 1 and nothing is output.
- Packet with valid=0 → forwarded with out_goe_valid=0 on the tail word; pkt_cnt increments.
- rst asserted on word 2 of a 5-word packet → outputs 0 the same cycle; FIFOs empty and counters 0 after release; the next packet is forwarded intact.
